lost_tx_arbiter: RTL

//  Shares the single serial transmitter among the NCH channel transition loggers inside system.

---
 rtl/lost_tx_arbiter_pkg.sv | 20 ++
 rtl/lost_tx_arbiter_rr_pick.sv | 33 +++
 rtl/lost_tx_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/lost_tx_arbiter_pkg.sv
// Shared FSM state encoding and frame header layout for the transition-log transmit arbiter.
// Header byte: {mark, 2'b00, level, channel[3:0]}, followed by timestamp bytes MSB first.
package lost_tx_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_SEND,
      ST_HOLD,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam logic HDR_MARK = 1'b1;

   function automatic logic [7:0] hdr_byte(input logic lvl, input logic [3:0] ch);
      return {HDR_MARK, 2'b00, lvl, ch};
   endfunction

endpackage

// File: rtl/lost_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid channel after rr_ptr, wrapping mod NCH.
// Zero latency; no backpressure of its own.
module lost_tx_arbiter_rr_pick
   import lost_tx_arbiter_pkg::*;
#(
   parameter int NCH = 4,
   parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0] req_valid,
   input  logic [PW-1:0]  rr_ptr,
   output logic [PW-1:0]  gnt_idx,
   output logic           any_req
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      gnt_idx = rr_ptr;
      found   = 1'b0;
      idx     = '0;
      for (int k = 1; k <= NCH; k++) begin
         idx = PW'((int'(rr_ptr) + k) % NCH);
         if (!found && req_valid[idx]) begin
            gnt_idx = idx;
            found   = 1'b1;
         end
      end
   end

   assign any_req = |req_valid;

endmodule

// File: rtl/lost_tx_arbiter.sv
// Round-robin arbiter feeding one byte-wide UART: grant, then header + TSW/8 timestamp bytes.
// Grant one cycle after the IDLE sample; each byte waits for tx_busy to fall before the next tx_start.
module lost_tx_arbiter
   import lost_tx_arbiter_pkg::*;
#(
   parameter int NCH = 4,
   parameter int TSW = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [NCH-1:0]   req_valid,
   input  logic [NCH-1:0]   req_lvl,
   input  logic [NCH*TSW-1:0] req_ts,
   output logic [NCH-1:0]   req_ready,
   output logic [7:0]       tx_data,
   output logic             tx_start,
   input  logic             tx_busy,
   output logic [15:0]      frame_cnt
);

   localparam int PW       = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TS_BYTES = TSW / 8;
   localparam int BIW      = $clog2(TS_BYTES + 1);

   state_t           state_q;
   logic [PW-1:0]    rr_ptr_q;
   logic [PW-1:0]    g_q;
   logic [TSW-1:0]   ts_q;
   logic [BIW-1:0]   byte_idx_q;
   logic [NCH-1:0]   req_ready_q;
   logic [7:0]       tx_data_q;
   logic             tx_start_q;
   logic [15:0]      frame_cnt_q;

   logic [PW-1:0]    gnt_idx;
   logic             any_req;

   lost_tx_arbiter_rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .gnt_idx   (gnt_idx),
      .any_req   (any_req)
   );

   // Byte k (k >= 1) of a frame is timestamp byte TS_BYTES-k, i.e. MSB first.
   function automatic logic [7:0] ts_byte(input logic [TSW-1:0] ts, input int k);
      logic [TSW-1:0] sh;
      sh = ts >> (8 * (TS_BYTES - k));
      return sh[7:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= PW'(NCH - 1);
         g_q         <= '0;
         ts_q        <= '0;
         byte_idx_q  <= '0;
         req_ready_q <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         req_ready_q <= '0;
         tx_start_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (enable && any_req) begin
                  g_q         <= gnt_idx;
                  req_ready_q <= NCH'(1) << gnt_idx;
                  state_q     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // Header goes out straight from the live level, so the registered tx_data lines up with SEND.
               ts_q       <= req_ts[int'(g_q)*TSW +: TSW];
               rr_ptr_q   <= g_q;
               byte_idx_q <= '0;
               tx_data_q  <= hdr_byte(req_lvl[g_q], 4'(g_q));
               tx_start_q <= 1'b1;
               state_q    <= ST_SEND;
            end
            ST_SEND: state_q <= ST_HOLD;
            ST_HOLD: state_q <= ST_WAIT;
            ST_WAIT: begin
               if (!tx_busy) begin
                  if (byte_idx_q == BIW'(TS_BYTES)) begin
                     state_q <= ST_DONE;
                  end else begin
                     byte_idx_q <= byte_idx_q + 1'b1;
                     tx_data_q  <= ts_byte(ts_q, int'(byte_idx_q) + 1);
                     tx_start_q <= 1'b1;
                     state_q    <= ST_SEND;
                  end
               end
            end
            ST_DONE: begin
               frame_cnt_q <= frame_cnt_q + 16'd1;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign tx_data   = tx_data_q;
   assign tx_start  = tx_start_q;
   assign frame_cnt = frame_cnt_q;

endmodule
